// File: rtl/alu_panel_sequencer.sv
// alu_panel_sequencer: uses two push-buttons to step a 4-op ALU through op select,
// operand A/B edit, execute and show, and reports values on three active-low LEDs.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   btn1, btn2        - raw active-low buttons (btn1 = advance, btn2 = modify)
//   alu_op/alu_a/alu_b- opcode and operands driven to the external ALU
//   alu_y             - combinational ALU result
//   result            - captured ALU result
//   result_valid      - high while showing the result
//   state             - FSM state code (debug)
//   led               - active-low LED drive
module alu_panel_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn1,
  input  logic       btn2,
  output logic [1:0] alu_op,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  input  logic [3:0] alu_y,
  output logic [3:0] result,
  output logic       result_valid,
  output logic [2:0] state,
  output logic [2:0] led
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_OP     = 3'd0,
    ST_EDIT_A = 3'd1,
    ST_EDIT_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SHOW   = 3'd4
  } state_t;

  // Index 0 = btn1 (advance), index 1 = btn2 (modify)
  logic [1:0]    sync1_q, sync2_q, level_q, press_q;
  logic [CW-1:0] cnt_q [2];

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] a_q, a_d, b_q, b_d;
  logic [3:0] result_q, result_d;
  logic [2:0] led_q, led_d;
  logic       valid_q, valid_d;
  logic       adv, mod;

  // Synchronize, debounce and turn accepted falling levels into one-cycle press pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      level_q  <= 2'b11;
      press_q  <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q <= {btn2, btn1};
      sync2_q <= sync1_q;
      press_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          // This cycle is the last required differing one: accept the new level
          level_q[i] <= sync2_q[i];
          cnt_q[i]   <= '0;
          press_q[i] <= ~sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Advance has priority over modify when both land in the same cycle
  assign adv = press_q[0];
  assign mod = press_q[1] & ~press_q[0];

  // Next-state, register updates and next LED/valid values
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    led_d    = 3'b111;
    valid_d  = 1'b0;

    case (state_q)
      ST_OP: begin
        if (adv)      state_d = ST_EDIT_A;
        else if (mod) op_d = op_q + 2'd1;
      end
      ST_EDIT_A: begin
        if (adv)      state_d = ST_EDIT_B;
        else if (mod) a_d = a_q + 3'd1;
      end
      ST_EDIT_B: begin
        if (adv)      state_d = ST_EXEC;
        else if (mod) b_d = b_q + 3'd1;
      end
      ST_EXEC: begin
        result_d = alu_y;
        state_d  = ST_SHOW;
      end
      ST_SHOW: begin
        if (adv) state_d = ST_OP;
      end
      default: state_d = ST_OP;
    endcase

    // LEDs are decoded from the values being registered, keeping them glitch-free
    case (state_d)
      ST_OP:     led_d = ~{1'b0, op_d};
      ST_EDIT_A: led_d = ~a_d;
      ST_EDIT_B: led_d = ~b_d;
      ST_SHOW:   led_d = ~result_d[2:0];
      default:   led_d = 3'b111;
    endcase
    valid_d = (state_d == ST_SHOW);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OP;
      op_q     <= 2'd0;
      a_q      <= 3'd2;
      b_q      <= 3'd3;
      result_q <= 4'h0;
      led_q    <= 3'b111;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      led_q    <= led_d;
      valid_q  <= valid_d;
    end
  end

  assign alu_op       = op_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign state        = state_q;
  assign led          = led_q;

endmodule

// File: tb/tb_alu_panel_sequencer.sv
// Testbench for alu_panel_sequencer: directed scenarios plus random button
// presses checked against a transaction-level model of the panel.
module tb_alu_panel_sequencer;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn1 = 1'b1;
  logic       btn2 = 1'b1;
  logic [1:0] alu_op;
  logic [2:0] alu_a, alu_b;
  logic [3:0] alu_y;
  logic [3:0] result;
  logic       result_valid;
  logic [2:0] state;
  logic [2:0] led;

  int checks = 0;
  int errors = 0;

  // Model of the panel, advanced once per accepted button event
  int m_state, m_op, m_a, m_b, m_res;

  alu_panel_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .btn1(btn1), .btn2(btn2),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .result(result), .result_valid(result_valid), .state(state), .led(led)
  );

  always #5 clk = ~clk;

  // Board ALU
  always_comb begin
    case (alu_op)
      2'b00:   alu_y = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   alu_y = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   alu_y = {1'b0, alu_a & alu_b};
      default: alu_y = {1'b0, alu_a | alu_b};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int calc(input int op, input int a, input int b);
    case (op)
      0:       return (a + b) % 16;
      1:       return (a - b + 16) % 16;
      2:       return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic int m_led();
    case (m_state)
      0:       return 7 - m_op;
      1:       return 7 - m_a;
      2:       return 7 - m_b;
      4:       return 7 - (m_res % 8);
      default: return 7;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_op = 0; m_a = 2; m_b = 3; m_res = 0;
  endtask

  // One press event; EXEC is transient so EDIT_B + advance lands in SHOW
  task automatic model_event(input bit b1, input bit b2);
    if (b1) begin
      case (m_state)
        0: m_state = 1;
        1: m_state = 2;
        2: begin m_res = calc(m_op, m_a, m_b); m_state = 4; end
        default: m_state = 0;
      endcase
    end else if (b2) begin
      case (m_state)
        0: m_op = (m_op + 1) % 4;
        1: m_a = (m_a + 1) % 8;
        2: m_b = (m_b + 1) % 8;
        default: ;
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".state"},  32'(state),        m_state);
    chk({tag, ".led"},    32'(led),          m_led());
    chk({tag, ".op"},     32'(alu_op),       m_op);
    chk({tag, ".a"},      32'(alu_a),        m_a);
    chk({tag, ".b"},      32'(alu_b),        m_b);
    chk({tag, ".result"}, 32'(result),       m_res);
    chk({tag, ".valid"},  32'(result_valid), (m_state == 4) ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; btn1 = 1'b1; btn2 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic press(input bit b1, input bit b2, input int hold, input int rel);
    @(negedge clk);
    btn1 = ~b1;
    btn2 = ~b2;
    repeat (hold) @(negedge clk);
    btn1 = 1'b1;
    btn2 = 1'b1;
    repeat (rel) @(negedge clk);
    model_event(b1, b2);
  endtask

  initial begin
    model_reset();

    // Reset and idle
    do_reset();
    repeat (20) @(negedge clk);
    check_model("reset");

    // Press latency: state must change on the (D+3)-th edge after the pin falls
    btn1 = 1'b0;
    repeat (D + 2) @(negedge clk);
    chk("lat_before", 32'(state), 0);
    @(negedge clk);
    chk("lat_after", 32'(state), 1);
    repeat (3) @(negedge clk);
    btn1 = 1'b1;
    repeat (10) @(negedge clk);
    model_event(1'b1, 1'b0);
    check_model("lat");

    // Second advance, then the third one observed through EXEC into SHOW
    press(1'b1, 1'b0, 10, 10);
    check_model("adv2");
    btn1 = 1'b0;
    repeat (D + 3) @(negedge clk);
    chk("exec.state", 32'(state), 3);
    chk("exec.led", 32'(led), 32'b111);
    chk("exec.valid", 32'(result_valid), 0);
    @(negedge clk);
    chk("show.state", 32'(state), 4);
    chk("show.result", 32'(result), 5);
    chk("show.led", 32'(led), 32'b010);
    chk("show.valid", 32'(result_valid), 1);
    repeat (2) @(negedge clk);
    btn1 = 1'b1;
    repeat (10) @(negedge clk);
    model_event(1'b1, 1'b0);
    check_model("add");

    // Subtract wraps: 2 - 3 = F
    do_reset();
    press(1'b0, 1'b1, 10, 10);
    check_model("op_sub");
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 10, 10);
    check_model("sub");
    chk("sub.result", 32'(result), 15);
    chk("sub.led", 32'(led), 0);

    // Reset while in SHOW
    do_reset();
    check_model("rst_show");

    // Bounces shorter than the debounce window produce no event
    @(negedge clk);
    btn1 = 1'b0;
    repeat (3) @(negedge clk);
    btn1 = 1'b1;
    repeat (2) @(negedge clk);
    btn1 = 1'b0;
    repeat (3) @(negedge clk);
    btn1 = 1'b1;
    repeat (10) @(negedge clk);
    check_model("bounce");
    press(1'b1, 1'b0, 6, 10);
    check_model("bounce_ok");

    // Both buttons at once in EDIT_A: advance wins, a untouched
    press(1'b1, 1'b1, 10, 10);
    check_model("both");
    chk("both.a", 32'(alu_a), 2);

    // Back round to EDIT_A and wrap a
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 8, 8);
    check_model("to_edit_a");
    for (int i = 0; i < 6; i++) press(1'b0, 1'b1, 8, 8);
    check_model("a_wrap");
    chk("a_wrap.a", 32'(alu_a), 0);

    // Random button traffic
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int k;
      k = int'($urandom_range(0, 2));
      press(k != 1, k != 0, int'($urandom_range(6, 10)), int'($urandom_range(6, 10)));
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
